even_parity_serial_rx: RTL and testbench
========================================

EVEN_PARITY_SERIAL_RX -- requirements
Module: even_parity_serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL have port data, output, 3 bits: last received data, data[2]=A, data[1]=B, data[0]=C.
REQ-006 SHALL have port valid, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-007 SHALL have port par_err, output, 1 bit: even-parity failure of the last frame.
REQ-008 SHALL have port frame_err, output, 1 bit: stop bit of the last frame sampled low.
REQ-009 SHALL have port err_cnt, output, 4 bits: saturating count of errored frames.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer; all sampling uses the synchronized value rxs.
REQ-011 SHALL use frame format: start(0), A, B, C, p, stop(1), each bit CLKS_PER_BIT cycles, MSB (A) first.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: on rxs==0, clear bit-timer, go START.
REQ-014 START: at timer == CLKS_PER_BIT/2-1 (mid-bit), if rxs==0 go DATA with timer cleared; else (glitch) return IDLE, no valid, no error.
REQ-015 DATA: sample rxs at timer == CLKS_PER_BIT-1, shift into 3-bit register A first; after the 3rd sample go PARITY.
REQ-016 PARITY: sample p at timer == CLKS_PER_BIT-1, go STOP.
REQ-017 STOP: sample at timer == CLKS_PER_BIT-1, then return IDLE in the next cycle (no wait for a full stop bit).
REQ-018 On the STOP sample edge: data <= shifted bits; par_err <= A^B^C^p; frame_err <= ~rxs; valid <= 1 for exactly one cycle.
REQ-019 data, par_err, frame_err SHALL hold until the next valid pulse; they do not change on glitched starts.
REQ-020 err_cnt SHALL increment by 1 on a valid pulse where par_err|frame_err is 1 (once per frame even if both are set), saturating at 15.
REQ-021 A parity error and a frame error in the same frame SHALL both be flagged.
REQ-022 rxs low while in IDLE immediately after STOP SHALL start a new frame (back-to-back frames supported).
REQ-023 Latency: valid asserts 2 (synchronizer) + CLKS_PER_BIT/2 + 5*CLKS_PER_BIT cycles after the rxd falling edge at the start bit, +/-1 cycle.
REQ-024 rxd changes during DATA/PARITY other than at sample points SHALL have no effect.

Reset
REQ-025 While rst is high: state IDLE, timer 0, shift register 0, synchronizer flops 1, data 0, valid 0, par_err 0, frame_err 0, err_cnt 0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no valid pulse; after release the receiver SHALL wait for a new high-to-low transition on rxs.

Verification (CLKS_PER_BIT=4)
REQ-027 Frame 0,1,0,1,0,1 (data 101, p 0) -> one valid pulse, data=3'b101, par_err=0, frame_err=0, err_cnt=0.
REQ-028 Frame 0,1,1,1,0,1 (p wrong) -> valid, data=3'b111, par_err=1, err_cnt=1.
REQ-029 Frame 0,0,0,1,1,0 (stop low) -> valid, data=3'b001, par_err=0, frame_err=1, err_cnt increments by 1.
REQ-030 rxd low for 1 clk only in idle -> no valid; data/flags unchanged.
REQ-031 17 consecutive bad-parity frames back-to-back -> 17 valid pulses, err_cnt stops at 15.
REQ-032 rst pulse during DATA of a frame -> no valid; all outputs 0; the next clean frame 0,0,1,1,0,1 decodes to data=3'b011, par_err=0.

Source files
------------

// File: rtl/even_parity_serial_rx.sv
// even_parity_serial_rx
//   Receives a 6-bit serial frame on rxd: start(0), A, B, C, p, stop(1). Each bit
//   lasts CLKS_PER_BIT clk cycles and A is sent first. The start bit is confirmed
//   at its middle. Every later bit is sampled one full bit time after the previous
//   sample, so each sample lands near the middle of its bit.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (even, >= 4)
// Ports
//   clk       : clock, rising-edge active
//   rst       : asynchronous active-high reset
//   rxd       : asynchronous serial input, idle high
//   data      : last received data {A, B, C}
//   valid     : one-cycle pulse when a frame completes
//   par_err   : even-parity failure (A^B^C^p) of the last frame
//   frame_err : stop bit of the last frame sampled low
//   err_cnt   : saturating count of frames with par_err or frame_err
module even_parity_serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [2:0] data,
  output logic       valid,
  output logic       par_err,
  output logic       frame_err,
  output logic [3:0] err_cnt
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMid = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TEnd = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {st_idle, st_start, st_data, st_parity, st_stop} state_t;

  logic          rx_meta, rxs;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    shift_q, shift_d;
  logic [1:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [2:0]    data_d;
  logic          valid_d, par_err_d, frame_err_d;
  logic [3:0]    err_cnt_d;
  logic          par_bad, stop_bad;

  // Two-flop synchronizer. It resets to the idle-high level, so a line held low
  // through reset only starts a frame once the low level reaches rxs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign par_bad  = ^{shift_q, par_q};
  assign stop_bad = ~rxs;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    data_d      = data;
    valid_d     = 1'b0;
    par_err_d   = par_err;
    frame_err_d = frame_err;
    err_cnt_d   = err_cnt;
    unique case (state_q)
      st_idle: begin
        timer_d = '0;
        if (!rxs) state_d = st_start;
      end
      st_start: begin
        if (timer_q == TMid) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          // A start bit that is no longer low at mid-bit is treated as a glitch.
          state_d   = rxs ? st_idle : st_data;
        end
      end
      st_data: begin
        if (timer_q == TEnd) begin
          timer_d   = '0;
          shift_d   = {shift_q[1:0], rxs};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 2'd2) state_d = st_parity;
        end
      end
      st_parity: begin
        if (timer_q == TEnd) begin
          timer_d = '0;
          par_d   = rxs;
          state_d = st_stop;
        end
      end
      st_stop: begin
        if (timer_q == TEnd) begin
          timer_d     = '0;
          state_d     = st_idle;
          data_d      = shift_q;
          par_err_d   = par_bad;
          frame_err_d = stop_bad;
          valid_d     = 1'b1;
          if ((par_bad || stop_bad) && (err_cnt != 4'd15)) err_cnt_d = err_cnt + 4'd1;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= st_idle;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      data      <= data_d;
      valid     <= valid_d;
      par_err   <= par_err_d;
      frame_err <= frame_err_d;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_even_parity_serial_rx.sv
// Scoreboard bench for even_parity_serial_rx (CLKS_PER_BIT = 4).
// Frames are driven bit by bit. The expected decode is computed from the frame
// rules and pushed into a queue. A monitor pops one entry per valid pulse and checks it.
module tb_even_parity_serial_rx;

  localparam int CPB = 4;
  // Latency from the first rising edge after rxd falls to the edge that raises valid.
  localparam int LAT = 2 + CPB / 2 + 5 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [2:0] data;
  logic       valid, par_err, frame_err;
  logic [3:0] err_cnt;

  even_parity_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .par_err   (par_err),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] d;
    logic       pe;
    logic       fe;
    logic [3:0] cnt;
    int         t_start;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // Reference state: what the receiver should report after the last frame sent.
  logic [2:0] m_data = '0;
  logic       m_pe = 1'b0;
  logic       m_fe = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Drives one frame starting at a negedge; returns at a negedge.
  task automatic send_frame(input logic [2:0] d, input logic p, input logic stop);
    logic [5:0] bits;
    exp_t       e;
    bits   = {1'b0, d, p, stop};
    m_data = d;
    m_pe   = d[2] ^ d[1] ^ d[0] ^ p;
    m_fe   = !stop;
    if ((m_pe || m_fe) && m_cnt < 15) m_cnt = m_cnt + 1;
    e.d = m_data; e.pe = m_pe; e.fe = m_fe; e.cnt = 4'(m_cnt); e.t_start = cyc;
    q.push_back(e);
    for (int i = 5; i >= 0; i--) begin
      rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_frames", q.size(), 0);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_data"}, int'(data), int'(m_data));
    chk({tag, "_par_err"}, int'(par_err), int'(m_pe));
    chk({tag, "_frame_err"}, int'(frame_err), int'(m_fe));
    chk({tag, "_err_cnt"}, int'(err_cnt), m_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, int'(data), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_par_err"}, int'(par_err), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got valid=1, expected no frame (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("data", int'(data), int'(e.d));
        chk("par_err", int'(par_err), int'(e.pe));
        chk("frame_err", int'(frame_err), int'(e.fe));
        chk("err_cnt", int'(err_cnt), int'(e.cnt));
        chk_range("latency", cyc - (e.t_start + 1), LAT - 1, LAT + 1);
      end
    end
  end

  initial begin
    logic [2:0] d;
    logic       p, stop;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(2 * CPB);

    // Directed frames: clean, parity error, frame error.
    send_frame(3'b101, 1'b0, 1'b1);
    send_frame(3'b111, 1'b0, 1'b1);
    send_frame(3'b001, 1'b1, 1'b0);
    idle(2 * CPB);
    drain();

    // One-cycle low glitch in idle: no frame, outputs held.
    rxd = 1'b0;
    @(negedge clk);
    idle(6 * CPB);
    chk_held("glitch");

    // 17 back-to-back bad-parity frames: counter saturates at 15.
    for (int i = 0; i < 17; i++) begin
      d = 3'($urandom_range(0, 7));
      send_frame(d, ~(d[2] ^ d[1] ^ d[0]), 1'b1);
    end
    drain();
    chk("saturated_err_cnt", int'(err_cnt), 15);

    // Reset during DATA: start bit plus part of A, then an asynchronous reset.
    idle(2 * CPB);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_reset");
    m_data = '0; m_pe = 1'b0; m_fe = 1'b0; m_cnt = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b0;
    idle(8 * CPB);
    chk_zero("after_abort");
    send_frame(3'b011, 1'b0, 1'b1);
    idle(CPB);
    drain();

    // Randomized frames with random gaps; a low stop bit needs an idle bit after it.
    for (int i = 0; i < 40; i++) begin
      d    = 3'($urandom_range(0, 7));
      p    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, p, stop);
      if (!stop) idle(CPB + int'($urandom_range(0, 3)));
      else idle(int'($urandom_range(0, 6)));
    end
    idle(2 * CPB);
    drain();
    chk_held("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
